// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / divide unit with HI/LO registers.
// A start is taken in IDLE, the unit runs 32 shift-add or restoring-division
// steps on operand magnitudes (CALC), then applies sign correction and writes
// HI/LO (FIX). All outputs are registers; no input reaches an output
// combinationally.
//
// Handshake: start is a request that is only accepted while busy=0 (the unit
// is in IDLE). Acceptance happens at the edge that samples start=1 in IDLE;
// busy rises the next cycle and stays high until the result is written, while
// start, hi_we and lo_we are ignored. done pulses for one cycle when HI/LO
// carry the new result; hi_we/lo_we are only honoured in IDLE with start=0.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    // Operation encodings: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;       // iteration index within CALC
    logic [1:0]  op_q;        // latched operation
    logic        a_neg;       // rs operand was negative (signed ops only)
    logic        b_neg;       // rt operand was negative (signed ops only)
    logic [31:0] b_mag;       // multiplicand magnitude or divisor magnitude
    logic [31:0] dividend_q;  // raw rs value, returned in HI on divide-by-zero
    logic [63:0] acc;         // {partial product | remainder, multiplier | quotient}

    // Operand preparation at acceptance time.
    logic        in_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    // One iteration of each algorithm.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_sub;
    logic        div_ge;
    logic [63:0] div_next;

    // Sign-corrected results written during FIX.
    logic        q_is_signed;
    logic        prod_neg;
    logic        quot_neg;
    logic        rem_neg;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic        fix_dbz;

    // Magnitudes of the incoming operands; only signed ops negate.
    always_comb begin
        in_signed = 1'b0;
        rs_neg    = 1'b0;
        rt_neg    = 1'b0;
        rs_mag    = rs_data;
        rt_mag    = rt_data;
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        rs_neg    = in_signed & rs_data[31];
        rt_neg    = in_signed & rt_data[31];
        if (rs_neg) rs_mag = ~rs_data + 32'd1;
        if (rt_neg) rt_mag = ~rt_data + 32'd1;
    end

    // Shift-add multiply step: add multiplicand when the low multiplier bit is
    // set, then shift the 65-bit {carry, acc} right by one.
    always_comb begin
        mul_sum  = 33'd0;
        mul_next = acc;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
    end

    // Restoring divide step: shift {rem, quot} left, subtract the divisor if
    // it fits and record the quotient bit. The remainder never exceeds the
    // divisor, so 33 bits hold the shifted value.
    always_comb begin
        div_shift = {acc[63:32], acc[31]};
        div_ge    = 1'b0;
        div_sub   = 33'd0;
        div_next  = acc;
        div_ge    = (div_shift >= {1'b0, b_mag});
        div_sub   = div_shift - {1'b0, b_mag};
        if (div_ge) div_next = {div_sub[31:0], acc[30:0], 1'b1};
        else        div_next = {div_shift[31:0], acc[30:0], 1'b0};
    end

    // Final sign fix and divide-by-zero substitution.
    always_comb begin
        q_is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        prod_neg    = q_is_signed & (a_neg ^ b_neg);
        quot_neg    = q_is_signed & (a_neg ^ b_neg);
        rem_neg     = q_is_signed & a_neg;
        prod        = acc;
        quot        = acc[31:0];
        rem         = acc[63:32];
        fix_hi      = 32'd0;
        fix_lo      = 32'd0;
        fix_dbz     = 1'b0;
        if (prod_neg) prod = ~acc + 64'd1;
        if (quot_neg) quot = ~acc[31:0] + 32'd1;
        if (rem_neg)  rem  = ~acc[63:32] + 32'd1;
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            if (b_mag == 32'd0) begin
                fix_hi  = dividend_q;
                fix_lo  = 32'hFFFF_FFFF;
                fix_dbz = 1'b1;
            end else begin
                fix_hi = rem;
                fix_lo = quot;
            end
        end else begin
            fix_hi = prod[63:32];
            fix_lo = prod[31:0];
        end
    end

    // Control FSM plus all architectural registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 5'd0;
            op_q       <= OP_MULT;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            b_mag      <= 32'd0;
            dividend_q <= 32'd0;
            acc        <= 64'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dbz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        a_neg      <= rs_neg;
                        b_neg      <= rt_neg;
                        dividend_q <= rs_data;
                        count      <= 5'd0;
                        busy       <= 1'b1;
                        dbz        <= 1'b0;
                        state      <= CALC;
                        if (op[1]) begin
                            b_mag <= rt_mag;
                            acc   <= {32'd0, rs_mag};
                        end else begin
                            b_mag <= rs_mag;
                            acc   <= {32'd0, rt_mag};
                        end
                    end else begin
                        if (hi_we) hi <= rs_data;
                        if (lo_we) lo <= rs_data;
                    end
                end
                CALC: begin
                    acc   <= op_q[1] ? div_next : mul_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    dbz   <= fix_dbz;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// cycle-level behavioural model built on plain 64-bit arithmetic.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dbz;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  mult_div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .dbz     (dbz)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {dbz, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    logic [64:0] r;
    r = 65'd0;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r = {1'b0, 64'(sp)};
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        r = {1'b0, up};
      end
      2'b10: begin
        if (b == 32'd0) r = {1'b1, a, 32'hFFFF_FFFF};
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          r = {1'b0, sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {1'b1, a, 32'hFFFF_FFFF};
        else r = {1'b0, a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Behavioural model: a countdown from acceptance to result write.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_dbz = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [64:0] m_res = 65'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= 32'd0;
      m_lo <= 32'd0;
      m_dbz <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 1) m_left <= m_left - 1;
      else if (m_left == 1) begin
        m_left <= 0;
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
        m_dbz <= m_res[64];
        m_done <= 1'b1;
      end else if (start) begin
        m_res <= model_res(op, rs_data, rt_data);
        m_left <= 33;
        m_dbz <= 1'b0;
      end else begin
        if (hi_we) m_hi <= rs_data;
        if (lo_we) m_lo <= rs_data;
      end
    end
  end

  // Scoreboard helper
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({busy, done, dbz, hi, lo} !== {(m_left > 0), m_done, m_dbz, m_hi, m_lo}) begin
        fails++;
        $display("FAIL cycle t=%0t: busy/done/dbz/hi/lo got %b%b%b %h %h expected %b%b%b %h %h",
                 $time, busy, done, dbz, hi, lo, (m_left > 0), m_done, m_dbz, m_hi, m_lo);
      end
    end
  end

  // Driver tasks
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    wait_done(1, lat);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int  lat;
  logic hi_ok;
  logic saw_done;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {32'd0, busy, done, dbz, hi}, 65'd0);
    check("reset_lo", {33'd0, lo}, 65'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Hand-computed values that pin the model.
    check("model_mult", model_res(2'b00, 32'hFFFF_FFFD, 32'd7), {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
    check("model_div_ovf", model_res(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 32'h0, 32'h8000_0000});
    check("model_divu_zero", model_res(2'b11, 32'd7, 32'd0), {1'b1, 32'd7, 32'hFFFF_FFFF});

    // MULT -3 * 7
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
    check("mult_latency", 65'(lat), 65'd34);
    check("mult_result", {done, hi, lo}, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(negedge clk);
    check("mult_done_once", {64'd0, done}, 65'd0);

    // MULTU max * max
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_result", {done, hi, lo}, {1'b1, 32'hFFFF_FFFE, 32'h0000_0001});

    // DIV -7 / 2
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_result", {dbz, hi, lo}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // DIVU 7 / 0
    do_op(2'b11, 32'd7, 32'd0, lat);
    check("divu_zero_latency", 65'(lat), 65'd34);
    check("divu_zero_result", {dbz, hi, lo}, {1'b1, 32'd7, 32'hFFFF_FFFF});

    // DIV overflow case
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_result", {dbz, hi, lo}, {1'b0, 32'h0, 32'h8000_0000});

    // Mid-operation start and hi_we are ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'hFFFF_FFFD; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hi_we = 1'b1; rs_data = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    wait_done(11, lat);
    check("protect_latency", 65'(lat), 65'd34);
    check("protect_result", {done, hi, lo}, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB});

    // Reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", {busy, hi, lo}, 65'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", {64'd0, saw_done}, 65'd0);
    lo_we = 1'b1; rs_data = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    check("idle_lo_we", {33'd0, lo}, {33'd0, 32'h0000_ABCD});

    // start together with hi_we in IDLE: HI keeps its value until the result.
    hi_we = 1'b1; rs_data = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    start = 1'b1; hi_we = 1'b1; op = 2'b11; rs_data = 32'h999; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    lat = 1;
    hi_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (hi !== 32'h55) hi_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("start_hiwe_hi_held", {64'd0, hi_ok}, {64'd0, 1'b1});
    check("start_hiwe_result", {done, hi, lo}, {1'b1, 32'd0, 32'h333});
    check("start_hiwe_latency", 65'(lat), 65'd34);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      hi_we   = ($urandom_range(0, 2) == 0);
      lo_we   = ($urandom_range(0, 2) == 0);
      op      = 2'($urandom_range(0, 3));
      rs_data = pick_operand();
      rt_data = pick_operand();
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port start, input, 1 bit: request a multiply/divide on the current operands.
REQ-004 SHALL have port op, input, 2 bits: operation code.
- 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port rs_data, input, 32 bits: register-file ReadData1 (multiplicand/dividend; MTHI/MTLO source).
REQ-006 SHALL have port rt_data, input, 32 bits: register-file ReadData2 (multiplier/divisor).
REQ-007 SHALL have port hi_we, input, 1 bit: MTHI, HI <= rs_data.
REQ-008 SHALL have port lo_we, input, 1 bit: MTLO, LO <= rs_data.
REQ-009 SHALL have port hi, output, 32 bits: HI register, feeding the register-file WriteData mux for MFHI.
REQ-010 SHALL have port lo, output, 32 bits: LO register, feeding the same mux for MFLO.
REQ-011 SHALL have port busy, output, 1 bit: operation in flight; the controller stalls MFHI/MFLO/MTHI/MTLO/start while high.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO hold a new result.
REQ-013 SHALL have port dbz, output, 1 bit: the last completed divide had a zero divisor.
- Held until the next accepted start.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX.
- IDLE->CALC on start.
- CALC->FIX after 32 iterations.
- FIX->IDLE unconditionally.
REQ-015 SHALL accept start only in IDLE.
- Operands and op are latched at acceptance (cycle N).
- Later changes on rs_data/rt_data/op have no effect on the operation in flight.
REQ-016 SHALL drive busy=1 in cycles N+1..N+33 (CALC 32 cycles, FIX 1 cycle) and busy=0 otherwise.
REQ-017 SHALL write HI/LO at the edge ending FIX, so that hi, lo and done=1 are valid in cycle N+34.
- done is 0 in every other cycle.
REQ-018 SHALL ignore start, hi_we and lo_we while busy=1.
REQ-019 SHALL, when start=1 in IDLE, accept start and ignore hi_we/lo_we in that cycle.
REQ-020 SHALL, in IDLE with start=0, apply hi_we/lo_we at the next edge; both may be asserted together.
REQ-021 SHALL compute multiply as a 32-step shift-add on operand magnitudes.
- MULT: operands two's-complement; 64-bit product negated in FIX if the operand signs differ.
- MULTU: operands unsigned.
- Result: {HI,LO} = 64-bit product.
REQ-022 SHALL compute divide as 32-step restoring division on magnitudes.
- LO = quotient, HI = remainder.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign (sign fix in FIX).
REQ-023 SHALL, for a divisor of 0 (DIV or DIVU), produce LO=0xFFFFFFFF, HI=dividend and dbz=1.
- Latency unchanged.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0x00000000 and dbz=0.
REQ-025 SHALL use no combinational path from any input to any output; all outputs are registered.

Reset
REQ-026 SHALL, with rst=1 at an edge, force state=IDLE, hi=0, lo=0, busy=0, done=0, dbz=0.
- rst has priority over start/hi_we/lo_we.
REQ-027 SHALL, on rst mid-operation (CALC or FIX), abandon the operation with no HI/LO update and no done pulse.
- Outputs read the reset values from the next cycle.

Verification
REQ-028 SHALL verify MULT: rs=0xFFFFFFFD (-3), rt=7, start at N -> busy N+1..N+33.
- At N+34: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for exactly one cycle.
REQ-029 SHALL verify MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at N+34.
REQ-030 SHALL verify DIV: rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Also check DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, dbz=1.
REQ-031 SHALL verify mid-operation protection during a running MULT.
- Pulse start with new operands at N+5 and hi_we with rs=0x1234 at N+10.
- Required: both ignored; final result is from the first operands; done at N+34 only.
REQ-032 SHALL verify rst=1 at N+20 of a DIV -> at N+21 hi=lo=0, busy=0; no done pulse follows.
- Afterwards, IDLE lo_we with rs=0xABCD -> lo=0x0000ABCD next cycle.
REQ-033 SHALL verify start and hi_we together in IDLE -> operation starts; HI unchanged until the result is written at N+34.
